// File: rtl/mont_pkg.sv
// Shared constants and types for the Montgomery multiply/reduce datapath.
// N = 2^64 - 15, N_INV = -N^-1 mod 2^64, R_SQR = 2^128 mod N.
package mont_pkg;

  localparam int unsigned RADIX_SIZE = 64;
  localparam logic [63:0] N          = 64'hFFFF_FFFF_FFFF_FFF1;
  localparam logic [63:0] N_INV      = 64'hEEEE_EEEE_EEEE_EEEF;
  localparam logic [63:0] R_SQR      = 64'd225;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StMq,
    StDone
  } state_e;

endpackage

// File: rtl/shift_add_unit.sv
// Conditional shifted add: sum = acc + (addend << shamt) when enabled, else acc.
module shift_add_unit #(
  parameter int unsigned Width = 128,
  parameter int unsigned ShW   = 6
) (
  input  logic             en_i,
  input  logic [Width-1:0] acc_i,
  input  logic [Width-1:0] addend_i,
  input  logic [ShW-1:0]   shamt_i,
  output logic [Width-1:0] sum_o
);

  always_comb begin
    sum_o = acc_i;
    if (en_i) begin
      sum_o = acc_i + (addend_i << shamt_i);
    end
  end

endmodule

// File: rtl/mont_operand_mul.sv
// Bit-serial operand stage of a Montgomery multiplier: T = a*b, then m = T*N' mod R.
// One shift-add unit is time-shared between the product and the m-quotient phases.
module mont_operand_mul #(
  parameter int unsigned            RADIX_SIZE = mont_pkg::RADIX_SIZE,
  parameter logic [RADIX_SIZE-1:0]  N_INV      = mont_pkg::N_INV
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [RADIX_SIZE-1:0]     a,
  input  logic [RADIX_SIZE-1:0]     b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*RADIX_SIZE-1:0]   t_out,
  output logic [RADIX_SIZE-1:0]     m_out
);
  import mont_pkg::*;

  localparam int unsigned   AccW    = 2 * RADIX_SIZE;
  localparam int unsigned   CntW    = (RADIX_SIZE > 1) ? $clog2(RADIX_SIZE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RADIX_SIZE - 1);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [RADIX_SIZE-1:0]   a_q, a_d;
  logic [RADIX_SIZE-1:0]   b_q, b_d;
  logic [AccW-1:0]         acc_q, acc_d;
  logic [RADIX_SIZE-1:0]   m_q, m_d;

  logic                    sa_en;
  logic [AccW-1:0]         sa_acc;
  logic [AccW-1:0]         sa_addend;
  logic [AccW-1:0]         sa_sum;

  shift_add_unit #(
    .Width (AccW),
    .ShW   (CntW)
  ) u_shift_add (
    .en_i     (sa_en),
    .acc_i    (sa_acc),
    .addend_i (sa_addend),
    .shamt_i  (cnt_q),
    .sum_o    (sa_sum)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    m_d       = m_q;
    sa_en     = 1'b0;
    sa_acc    = acc_q;
    sa_addend = {{RADIX_SIZE{1'b0}}, a_q};

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          m_d     = '0;
          cnt_d   = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        sa_en = b_q[cnt_q];
        acc_d = sa_sum;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StMq;
        end
      end
      StMq: begin
        // Only the low half of the shared sum is kept, which gives the mod-R wrap for m.
        sa_en     = N_INV[cnt_q];
        sa_acc    = {{RADIX_SIZE{1'b0}}, m_q};
        sa_addend = {{RADIX_SIZE{1'b0}}, acc_q[RADIX_SIZE-1:0]};
        m_d       = sa_sum[RADIX_SIZE-1:0];
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    t_out     = acc_q;
    m_out     = m_q;
  end

endmodule
